// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave responder.
// State encoding, field widths and command codes.
package spi_slave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDATA,
      ST_DRAIN
   } state_t;

   localparam int CMD_W_DEF  = 4;
   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 16;
   localparam int SYNC_DEF   = 2;

   localparam logic [3:0] CMD_WR_DEF = 4'hB;
   localparam logic [3:0] CMD_RD_DEF = 4'hA;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Single-bit synchroniser into PCLK with edge strobes.
// Reset low so a held-low nss never fakes a falling edge.
module spi_in_sync
   import spi_slave_pkg::*;
#(
   parameter int STAGES = SYNC_DEF
) (
   input  logic PCLK,
   input  logic PRSTN,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Metastability chain followed by one history flop for edge detect.
   always_ff @(posedge PCLK or negedge PRSTN) begin
      if (!PRSTN) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: cmd/addr/data frames into a small register file.
// All SPI pins oversampled in PCLK; miso changes on sck falls only.
module spi_slave_responder
   import spi_slave_pkg::*;
#(
   parameter int                CMD_W       = CMD_W_DEF,
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                DATA_W      = DATA_W_DEF,
   parameter logic [CMD_W-1:0]  CMD_WR      = CMD_WR_DEF,
   parameter logic [CMD_W-1:0]  CMD_RD      = CMD_RD_DEF,
   parameter int                SYNC_STAGES = SYNC_DEF
) (
   input  logic              PCLK,
   input  logic              PRSTN,
   input  logic              sck,
   input  logic              nss,
   input  logic              mosi,
   output logic              miso,
   output logic              busy,
   output logic              wr_done,
   output logic              rd_done,
   output logic              frame_err,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(max3(CMD_W, ADDR_W, DATA_W)) + 1;

   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic sck_rise, sck_fall, nss_rise, nss_fall, mosi_s;
   logic unused_sck_q, unused_nss_q;
   logic unused_mosi_rise, unused_mosi_fall;

   spi_in_sync #(.STAGES(SYNC_STAGES)) u_sck (
      .PCLK (PCLK),
      .PRSTN(PRSTN),
      .d    (sck),
      .q    (unused_sck_q),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES)) u_nss (
      .PCLK (PCLK),
      .PRSTN(PRSTN),
      .d    (nss),
      .q    (unused_nss_q),
      .rise (nss_rise),
      .fall (nss_fall)
   );

   spi_in_sync #(.STAGES(SYNC_STAGES)) u_mosi (
      .PCLK (PCLK),
      .PRSTN(PRSTN),
      .d    (mosi),
      .q    (mosi_s),
      .rise (unused_mosi_rise),
      .fall (unused_mosi_fall)
   );

   state_t              state, state_d;
   logic [CNT_W-1:0]    bit_cnt;
   logic [CMD_W-1:0]    cmd_sh;
   logic [ADDR_W-1:0]   addr_sh;
   logic [DATA_W-1:0]   data_sh;
   logic [DATA_W-1:0]   rd_sh;
   logic                err_flag;
   logic [DATA_W-1:0]   regs [DEPTH];

   logic cnt_clr, cnt_inc;
   logic sh_cmd, sh_addr, sh_data;
   logic wr_pulse, rd_pulse, ferr_pulse;
   logic err_set, err_clr;
   logic rd_load, rd_shift;

   // State register.
   always_ff @(posedge PCLK or negedge PRSTN) begin
      if (!PRSTN) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Next-state and datapath control; nss_rise outranks any sck strobe.
   always_comb begin
      state_d    = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      sh_cmd     = 1'b0;
      sh_addr    = 1'b0;
      sh_data    = 1'b0;
      wr_pulse   = 1'b0;
      rd_pulse   = 1'b0;
      ferr_pulse = 1'b0;
      err_set    = 1'b0;
      err_clr    = 1'b0;
      rd_load    = 1'b0;
      rd_shift   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            err_clr = 1'b1;
            if (nss_fall) begin
               state_d = ST_CMD;
               cnt_clr = 1'b1;
            end
         end
         ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA: begin
            if (nss_rise) begin
               state_d    = ST_IDLE;
               cnt_clr    = 1'b1;
               ferr_pulse = 1'b1;
            end else begin
               if (state == ST_RDATA && sck_fall) begin
                  rd_load  = (bit_cnt == '0);
                  rd_shift = (bit_cnt != '0);
               end
               if (sck_rise) begin
                  cnt_inc = 1'b1;
                  unique case (state)
                     ST_CMD: begin
                        sh_cmd = 1'b1;
                        if (bit_cnt == CMD_LAST) begin
                           state_d = ST_ADDR;
                           cnt_clr = 1'b1;
                        end
                     end
                     ST_ADDR: begin
                        sh_addr = 1'b1;
                        if (bit_cnt == ADDR_LAST) begin
                           cnt_clr = 1'b1;
                           if (cmd_sh == CMD_WR) begin
                              state_d = ST_WDATA;
                           end else if (cmd_sh == CMD_RD) begin
                              state_d = ST_RDATA;
                           end else begin
                              state_d = ST_DRAIN;
                              err_set = 1'b1;
                           end
                        end
                     end
                     ST_WDATA: begin
                        sh_data = 1'b1;
                        if (bit_cnt == DATA_LAST) begin
                           state_d  = ST_DRAIN;
                           cnt_clr  = 1'b1;
                           wr_pulse = 1'b1;
                        end
                     end
                     default: begin
                        if (bit_cnt == DATA_LAST) begin
                           state_d  = ST_DRAIN;
                           cnt_clr  = 1'b1;
                           rd_pulse = 1'b1;
                        end
                     end
                  endcase
               end
            end
         end
         ST_DRAIN: begin
            if (nss_rise) begin
               state_d    = ST_IDLE;
               ferr_pulse = err_flag;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Counter, shifters, register file, pulses and miso driver.
   always_ff @(posedge PCLK or negedge PRSTN) begin
      if (!PRSTN) begin
         bit_cnt   <= '0;
         cmd_sh    <= '0;
         addr_sh   <= '0;
         data_sh   <= '0;
         rd_sh     <= '0;
         err_flag  <= 1'b0;
         miso      <= 1'b0;
         wr_done   <= 1'b0;
         rd_done   <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         wr_done   <= wr_pulse;
         rd_done   <= rd_pulse;
         frame_err <= ferr_pulse;
         if (cnt_clr)      bit_cnt <= '0;
         else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);
         if (sh_cmd)  cmd_sh  <= {cmd_sh[CMD_W-2:0], mosi_s};
         if (sh_addr) addr_sh <= {addr_sh[ADDR_W-2:0], mosi_s};
         if (sh_data) data_sh <= {data_sh[DATA_W-2:0], mosi_s};
         if (wr_pulse) regs[addr_sh] <= {data_sh[DATA_W-2:0], mosi_s};
         if (err_clr)      err_flag <= 1'b0;
         else if (err_set) err_flag <= 1'b1;
         if (state_d != ST_RDATA) begin
            miso <= 1'b0;
         end else if (rd_load) begin
            miso  <= regs[addr_sh][DATA_W-1];
            rd_sh <= regs[addr_sh] << 1;
         end else if (rd_shift) begin
            miso  <= rd_sh[DATA_W-1];
            rd_sh <= rd_sh << 1;
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign dbg_rdata = regs[dbg_addr];

endmodule
